mcpu_mem_initiator: RTL and testbench
=====================================

Name: mcpu_mem_initiator

Overview:
Initiator side of the MCPU RAM controller interface. It turns core-side data load/store requests into single-cycle RAM strobes on the data port (we/re/addr/datawr/datard). It also runs a sequential instruction prefetcher on the instruction port (instraddr/instrrd), feeding a small FIFO. It sits between the MCPU core and the RAM controller and is the only block that drives the RAM controller inputs.

Parameters:
WORD_SIZE, 8, data/instruction word width
ADDR_WIDTH, 8, address width; address space is 2^ADDR_WIDTH words
FETCH_DEPTH, 2, prefetch FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core data request valid
req_ready  out  1  high when a data request can be accepted
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  data address
req_wdata  in  WORD_SIZE  store data
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_rdata  out  WORD_SIZE  load data; valid while rsp_valid is high
pc_load  in  1  redirect fetch stream
pc_value  in  ADDR_WIDTH  new fetch address
instr_valid  out  1  FIFO head valid
instr_ready  in  1  core consumes FIFO head
instr_data  out  WORD_SIZE  FIFO head word
instr_addr  out  ADDR_WIDTH  address of FIFO head word
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM data read strobe
ram_addr  out  ADDR_WIDTH  RAM data address
ram_datawr  out  WORD_SIZE  RAM write data
ram_datard  in  WORD_SIZE  RAM data read (combinational from ram_addr/ram_re)
ram_instraddr  out  ADDR_WIDTH  RAM instruction address
ram_instrrd  in  WORD_SIZE  RAM instruction read (combinational)

Behaviour:
Reset values:
- All outputs are 0; req_ready=0 while rst_n is low.
- Data FSM is in IDLE; FIFO is empty; fetch pointer fpc=0.

Reset mid-operation:
- Asserting rst_n aborts any access immediately. No rsp_valid is produced for the aborted request.
- ram_we/ram_re drop combinationally with reset.

Data FSM states: IDLE, WR, RD, RSP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata and go to WR (store) or RD (load).
- WR: ram_we=1, ram_addr, ram_datawr driven for exactly one cycle, then go to RSP.
- RD: ram_re=1, ram_addr driven for one cycle; capture ram_datard into rsp_rdata at the end of the cycle; go to RSP.
- RSP: rsp_valid=1 for one cycle (no backpressure); req_ready=0; go to IDLE. rsp_rdata is unchanged on stores.
- Latency: a request accepted at edge N gives a strobe cycle N..N+1 and rsp_valid in cycle N+1..N+2. Throughput is one request per 3 cycles.
- Outside WR/RD, ram_we=ram_re=0 and ram_addr/ram_datawr hold their last values.
- Read-after-write to the same address returns the new data, because the accesses are strictly serialised.

Fetch path:
- ram_instraddr=fpc at all times.
- Each cycle the FIFO pushes {fpc, ram_instrrd} and increments fpc when count<FETCH_DEPTH, or when count==FETCH_DEPTH and a pop occurs in the same cycle.
- fpc wraps from 2^ADDR_WIDTH-1 to 0.
- A pop occurs on instr_valid&&instr_ready.
- instr_valid = count!=0. instr_data and instr_addr show the head entry.
- pc_load has priority over push and pop: FIFO is cleared, fpc<=pc_value, instr_valid=0 in the next cycle, and the first word arrives the cycle after that.
- The fetch path runs concurrently with, and independently of, the data FSM.

Optional Feature:
MCPU_SMC_SNOOP_EN:
- With the macro defined: in a WR cycle whose ram_addr equals the address of any valid FIFO entry, the FIFO is flushed and fpc is set to the head entry's address. Stale instructions are refetched. Ordinary pc_load takes precedence if both occur in the same cycle.
- Without the macro: no snooping. Already-prefetched words may be stale after a store, and software must issue pc_load.

Decomposition:
- Package mcpu_mem_pkg: default WORD_SIZE/ADDR_WIDTH constants, the data FSM state enum (IDLE/WR/RD/RSP), and the fetch entry struct {addr, data}.
- Sub-module mcpu_prefetch_fifo: parameterised FIFO with push, pop, flush, count, head outputs, and an address-match flag for the snoop feature.

Test Plan:
- Store pattern 9,3,7,4,4,5,6,4 repeated to addresses 0..255, then load each address -> each rsp_valid pulse carries the matching word; ram_we is high exactly 256 cycles in total.
- Store 0xA5 to 0x10 and immediately load 0x10 -> rsp_rdata=0xA5 two cycles after load acceptance.
- pc_load with 0xFE, instr_ready=1 -> instr_addr sequence 0xFE, 0xFF, 0x00, 0x01; data matches memory.
- instr_ready=0 for 10 cycles -> count stays 2; fpc advances by exactly 2; no word is lost or duplicated when ready rises.
- rst_n pulsed low during RD -> no rsp_valid, all outputs 0; the next request completes normally.
- With MCPU_SMC_SNOOP_EN, store 0x77 to the FIFO head address -> FIFO flushed; refetched head word is 0x77.

Source files
------------

// File: rtl/mcpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_mem_pkg
// Shared definitions for the MCPU memory initiator slice:
//   - default word/address widths and prefetch depth
//   - data-port FSM state encoding
//   - default prefetch FIFO entry layout {addr, data}
// -----------------------------------------------------------------------------
package mcpu_mem_pkg;

   localparam int WORD_SIZE_DEF   = 8;
   localparam int ADDR_WIDTH_DEF  = 8;
   localparam int FETCH_DEPTH_DEF = 2;

   // Data-port sequencing: accept, one strobe cycle, one response cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RSP  = 2'd3
   } data_state_t;

   // One prefetched instruction word together with the address it came from.
   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [WORD_SIZE_DEF-1:0]  data;
   } fetch_entry_t;

endpackage

// File: rtl/mcpu_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// mcpu_prefetch_fifo
// Small circular FIFO holding prefetched {addr, data} entries.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         drop all entries (wins over push/pop in the same cycle)
//   push          write push_entry; accepted when not full or when popping
//   push_entry    entry to store
//   pop           advance the head; ignored when empty
//   count         number of valid entries (0..DEPTH)
//   head          entry at the read pointer
//   match_addr    address compared against every valid entry
//   match_hit     1 when any valid entry holds match_addr
// DEPTH must be a power of two so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module mcpu_prefetch_fifo
   import mcpu_mem_pkg::*;
#(
   parameter int  DEPTH   = FETCH_DEPTH_DEF,
   parameter int  AW      = ADDR_WIDTH_DEF,
   parameter type entry_t = fetch_entry_t
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  entry_t                     push_entry,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output entry_t                     head,
   input  logic [AW-1:0]              match_addr,
   output logic                       match_hit
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   entry_t        mem_r [DEPTH];
   logic          push_ok_s;
   logic          pop_ok_s;
   logic [PW-1:0] off_s [DEPTH];

   // Qualify push/pop against the current fill level.
   always_comb begin
      pop_ok_s  = pop && (count_r != CW'(0));
      push_ok_s = push && ((count_r < CW'(DEPTH)) || pop_ok_s);
   end

   // Pointer, count and storage update; storage is not cleared by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= PW'(0);
         wr_ptr_r <= PW'(0);
         count_r  <= CW'(0);
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= entry_t'(0);
         end
      end else if (flush) begin
         rd_ptr_r <= PW'(0);
         wr_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Address match over live entries only: slot i is live when its distance
   // from the read pointer is below the fill level.
   always_comb begin
      match_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off_s[i] = PW'(i) - rd_ptr_r;
         if (({1'b0, off_s[i]} < count_r) && (mem_r[i].addr == match_addr)) begin
            match_hit = 1'b1;
         end else begin
            match_hit = match_hit;
         end
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mcpu_mem_initiator.sv
// -----------------------------------------------------------------------------
// mcpu_mem_initiator
// Sole driver of the RAM controller inputs. Two independent paths:
//   - data port: core load/store requests become single-cycle ram_we/ram_re
//     strobes, followed by a one-cycle rsp_valid pulse (3 cycles/request).
//   - fetch port: sequential prefetcher reading ram_instrrd at fpc into a
//     small FIFO presented to the core as instr_valid/instr_data/instr_addr.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_we/req_addr/req_wdata   core data request
//   rsp_valid/rsp_rdata             completion pulse and load data
//   pc_load/pc_value                fetch redirect
//   instr_valid/instr_ready/instr_data/instr_addr   prefetch FIFO head
//   ram_we/ram_re/ram_addr/ram_datawr/ram_datard    RAM data port
//   ram_instraddr/ram_instrrd       RAM instruction port
// Build option:
//   MCPU_SMC_SNOOP_EN  a store hitting any prefetched address flushes the
//                      FIFO and restarts fetch at the head address.
// -----------------------------------------------------------------------------
module mcpu_mem_initiator
   import mcpu_mem_pkg::*;
#(
   parameter int WORD_SIZE   = WORD_SIZE_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int FETCH_DEPTH = FETCH_DEPTH_DEF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]  req_wdata,
   output logic                  rsp_valid,
   output logic [WORD_SIZE-1:0]  rsp_rdata,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_value,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [WORD_SIZE-1:0]  instr_data,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WORD_SIZE-1:0]  ram_datawr,
   input  logic [WORD_SIZE-1:0]  ram_datard,
   output logic [ADDR_WIDTH-1:0] ram_instraddr,
   input  logic [WORD_SIZE-1:0]  ram_instrrd
);

   localparam int CW = $clog2(FETCH_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  data;
   } entry_t;

   // ---------------------------------------------------------------- data port
   data_state_t           state_r;
   data_state_t           state_nxt_s;
   logic                  accept_s;
   logic                  req_ready_r;
   logic                  ram_we_r;
   logic                  ram_re_r;
   logic                  rsp_valid_r;
   logic [ADDR_WIDTH-1:0] ram_addr_r;
   logic [WORD_SIZE-1:0]  ram_datawr_r;
   logic [WORD_SIZE-1:0]  rsp_rdata_r;

   // Next-state decode for the data FSM.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid && req_ready_r) begin
               accept_s    = 1'b1;
               state_nxt_s = req_we ? WR : RD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WR:      state_nxt_s = RSP;
         RD:      state_nxt_s = RSP;
         RSP:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Data FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered data-port outputs, decoded from the state being entered so
   // strobes line up exactly with the WR/RD cycle. req_ready stays low until
   // the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready_r  <= 1'b0;
         ram_we_r     <= 1'b0;
         ram_re_r     <= 1'b0;
         rsp_valid_r  <= 1'b0;
         ram_addr_r   <= {ADDR_WIDTH{1'b0}};
         ram_datawr_r <= {WORD_SIZE{1'b0}};
         rsp_rdata_r  <= {WORD_SIZE{1'b0}};
      end else begin
         req_ready_r <= (state_nxt_s == IDLE);
         ram_we_r    <= (state_nxt_s == WR);
         ram_re_r    <= (state_nxt_s == RD);
         rsp_valid_r <= (state_nxt_s == RSP);
         if (accept_s) begin
            ram_addr_r <= req_addr;
         end
         // Write data only changes for stores so it holds through loads.
         if (accept_s && req_we) begin
            ram_datawr_r <= req_wdata;
         end
         if (state_r == RD) begin
            rsp_rdata_r <= ram_datard;
         end
      end
   end

   assign req_ready  = req_ready_r;
   assign ram_we     = ram_we_r;
   assign ram_re     = ram_re_r;
   assign ram_addr   = ram_addr_r;
   assign ram_datawr = ram_datawr_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_rdata  = rsp_rdata_r;

   // --------------------------------------------------------------- fetch path
   logic [ADDR_WIDTH-1:0] fpc_r;
   logic [CW-1:0]         count_s;
   entry_t                head_s;
   entry_t                push_entry_s;
   logic                  instr_valid_s;
   logic                  pop_s;
   logic                  fetch_push_s;
   logic                  flush_s;
   logic                  match_hit_s;
   logic                  snoop_hit_s;

   assign instr_valid_s = (count_s != CW'(0));
   assign pop_s         = instr_valid_s && instr_ready;
   // Fill whenever a slot is free, including the slot freed by this pop.
   assign fetch_push_s  = (count_s < CW'(FETCH_DEPTH)) || pop_s;
   assign flush_s       = pc_load || snoop_hit_s;

   assign push_entry_s.addr = fpc_r;
   assign push_entry_s.data = ram_instrrd;

`ifdef MCPU_SMC_SNOOP_EN
   // A store landing on any prefetched word invalidates the prefetch.
   assign snoop_hit_s = ram_we_r && match_hit_s;
`else
   logic unused_match_s;
   assign unused_match_s = match_hit_s;
   assign snoop_hit_s    = 1'b0;
`endif

   // Fetch pointer: redirect, then snoop restart at the head, then advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc_r <= {ADDR_WIDTH{1'b0}};
      end else if (pc_load) begin
         fpc_r <= pc_value;
      end else if (snoop_hit_s) begin
         fpc_r <= head_s.addr;
      end else if (fetch_push_s) begin
         fpc_r <= fpc_r + ADDR_WIDTH'(1);
      end else begin
         fpc_r <= fpc_r;
      end
   end

   mcpu_prefetch_fifo #(
      .DEPTH   (FETCH_DEPTH),
      .AW      (ADDR_WIDTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush_s),
      .push       (fetch_push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .count      (count_s),
      .head       (head_s),
      .match_addr (ram_addr_r),
      .match_hit  (match_hit_s)
   );

   assign ram_instraddr = fpc_r;
   assign instr_valid   = instr_valid_s;
   assign instr_data    = head_s.data;
   assign instr_addr    = head_s.addr;

endmodule

// File: tb/tb_mcpu_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_mcpu_mem_initiator
// Directed + randomized bench for mcpu_mem_initiator. A behavioural RAM is
// attached to both ports; ref_mem is the bench's own view of memory contents,
// updated from the stores the bench issues. Honours MCPU_SMC_SNOOP_EN.
// -----------------------------------------------------------------------------
module tb_mcpu_mem_initiator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       pc_load;
   logic [7:0] pc_value;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr_data;
   logic [7:0] instr_addr;
   logic       ram_we;
   logic       ram_re;
   logic [7:0] ram_addr;
   logic [7:0] ram_datawr;
   logic [7:0] ram_datard;
   logic [7:0] ram_instraddr;
   logic [7:0] ram_instrrd;

   always #5 clk = ~clk;

   mcpu_mem_initiator dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .pc_load       (pc_load),
      .pc_value      (pc_value),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_data    (instr_data),
      .instr_addr    (instr_addr),
      .ram_we        (ram_we),
      .ram_re        (ram_re),
      .ram_addr      (ram_addr),
      .ram_datawr    (ram_datawr),
      .ram_datard    (ram_datard),
      .ram_instraddr (ram_instraddr),
      .ram_instrrd   (ram_instrrd)
   );

   // ------------------------------------------------------ behavioural RAM
   bit   [7:0] mem [256];
   bit         written [256];
   logic [7:0] seed8;
   int         we_cycles = 0;

   always @(posedge clk) begin
      if (ram_we === 1'b1) begin
         mem[ram_addr]     <= ram_datawr;
         written[ram_addr] <= 1'b1;
         we_cycles         <= we_cycles + 1;
      end
   end

   assign ram_datard  = (ram_re === 1'b1) ?
                        (written[ram_addr] ? mem[ram_addr] : ((ram_addr * 8'd37) ^ seed8)) : 8'h00;
   assign ram_instrrd = written[ram_instraddr] ? mem[ram_instraddr]
                                               : ((ram_instraddr * 8'd37) ^ seed8);

   // ------------------------------------------------------ reference model
   logic [7:0] ref_mem [256];
   logic [7:0] exp_rdata;
   logic [7:0] exp_datawr;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full request: accept, strobe cycle, response cycle, back to ready.
   task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] d);
      int guard;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      if (we) exp_datawr = d;
      chk("strobe_we", 32'(ram_we), 32'(we));
      chk("strobe_re", 32'(ram_re), 32'(!we));
      chk("strobe_addr", 32'(ram_addr), 32'(a));
      chk("strobe_datawr", 32'(ram_datawr), 32'(exp_datawr));
      chk("rsp_early", 32'(rsp_valid), 32'd0);
      if (we) ref_mem[a] = d;
      else    exp_rdata  = ref_mem[a];
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      chk("rsp_we_low", 32'(ram_we), 32'd0);
      chk("rsp_re_low", 32'(ram_re), 32'd0);
      chk("rsp_addr_hold", 32'(ram_addr), 32'(a));
      chk("rsp_not_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rsp_done", 32'(rsp_valid), 32'd0);
      chk("ready_again", 32'(req_ready), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_re"}, 32'(ram_re), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_datawr"}, 32'(ram_datawr), 32'd0);
      chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_instr_data"}, 32'(instr_data), 32'd0);
      chk({tag, "_instr_addr"}, 32'(instr_addr), 32'd0);
      chk({tag, "_instraddr"}, 32'(ram_instraddr), 32'd0);
   endtask

   logic [7:0] pat [8];
   logic [7:0] p;
   logic [7:0] exp_a;
   logic [7:0] old_word;
   int         we0;
   int         pops;

   initial begin
      pat = '{8'd9, 8'd3, 8'd7, 8'd4, 8'd4, 8'd5, 8'd6, 8'd4};
      seed8 = 8'($urandom);
      for (int a = 0; a < 256; a++) ref_mem[a] = (8'(a) * 8'd37) ^ seed8;
      exp_rdata   = 8'h00;
      exp_datawr  = 8'h00;
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = 8'h00;
      req_wdata   = 8'h00;
      pc_load     = 1'b0;
      pc_value    = 8'h00;
      instr_ready = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
      chk("fetch_reset_valid", 32'(instr_valid), 32'd1);
      chk("fetch_reset_addr", 32'(instr_addr), 32'd0);
      chk("fetch_reset_data", 32'(instr_data), 32'(ref_mem[0]));
      chk("fetch_reset_fpc", 32'(ram_instraddr), 32'd2);

      // Pattern stores over the whole space, then read everything back.
      we0 = we_cycles;
      for (int a = 0; a < 256; a++) do_req(1'b1, 8'(a), pat[a % 8]);
      chk("we_cycles_store", 32'(we_cycles - we0), 32'd256);
      for (int a = 0; a < 256; a++) do_req(1'b0, 8'(a), 8'h00);
      chk("we_cycles_total", 32'(we_cycles - we0), 32'd256);

      // Read-after-write to the same address.
      do_req(1'b1, 8'h10, 8'hA5);
      do_req(1'b0, 8'h10, 8'h00);
      chk("raw_a5", 32'(rsp_rdata), 32'hA5);

      // Randomized traffic with random idle gaps.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_req(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end

      // Redirect across the top of the address space, core always ready.
      pc_load     = 1'b1;
      pc_value    = 8'hFE;
      instr_ready = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      chk("redirect_bubble", 32'(instr_valid), 32'd0);
      exp_a = 8'hFE;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("wrap_valid", 32'(instr_valid), 32'd1);
         chk("wrap_addr", 32'(instr_addr), 32'(exp_a));
         chk("wrap_data", 32'(instr_data), 32'(ref_mem[exp_a]));
         exp_a = exp_a + 8'd1;
      end
      instr_ready = 1'b0;

      // Stall for 10 cycles, then drain with random ready.
      p        = 8'($urandom);
      pc_load  = 1'b1;
      pc_value = p;
      @(negedge clk);
      pc_load = 1'b0;
      repeat (10) @(negedge clk);
      chk("stall_fpc", 32'(ram_instraddr), 32'(p + 8'd2));
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_head", 32'(instr_addr), 32'(p));
      exp_a = p;
      pops  = 0;
      for (int i = 0; i < 80; i++) begin
         instr_ready = 1'($urandom_range(0, 1));
         if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            chk("stream_addr", 32'(instr_addr), 32'(exp_a));
            chk("stream_data", 32'(instr_data), 32'(ref_mem[exp_a]));
            exp_a = exp_a + 8'd1;
            pops++;
         end
         @(negedge clk);
      end
      instr_ready = 1'b0;
      chk("stream_progress", 32'(pops >= 10), 32'd1);

      // Reset in the middle of a load.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h33;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_before_reset", 32'(ram_re), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      @(negedge clk);
      chk("midreset_no_rsp1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("midreset_no_rsp2", 32'(rsp_valid), 32'd0);
      rst_n      = 1'b1;
      exp_rdata  = 8'h00;
      exp_datawr = 8'h00;
      @(negedge clk);
      chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
      do_req(1'b0, 8'h33, 8'h00);
      do_req(1'b1, 8'h34, 8'h5C);
      do_req(1'b0, 8'h34, 8'h00);

      // Store onto the prefetched head word.
      p        = 8'h40;
      pc_load  = 1'b1;
      pc_value = p;
      @(negedge clk);
      pc_load = 1'b0;
      repeat (5) @(negedge clk);
      old_word = ref_mem[p];
      do_req(1'b1, p, 8'h77);
      chk("snoop_head_addr", 32'(instr_addr), 32'(p));
`ifdef MCPU_SMC_SNOOP_EN
      chk("snoop_refetch", 32'(instr_data), 32'h77);
`else
      chk("no_snoop_stale", 32'(instr_data), 32'(old_word));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
